// File: rtl/soc_system_nios2_gen2_0_cpu_ocimem_arbiter_pkg.sv
// Shared types and constants for the OCI memory arbiter: FSM states, access
// owner, JTAG opcode and the bit positions of the jdo command fields.
package soc_system_nios2_gen2_0_cpu_ocimem_arbiter_pkg;

  // FSM states kept as plain constants so legacy tools see a fixed encoding.
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StWr    = 2'd1;
  localparam state_t StRd    = 2'd2;
  localparam state_t StRdCap = 2'd3;

  typedef enum logic {
    OWN_AV   = 1'b0,
    OWN_JTAG = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    JopNone  = 2'd0,
    JopRead  = 2'd1,
    JopWrite = 2'd2
  } jop_t;

  localparam int unsigned JdoWidth    = 38;
  localparam int unsigned JdoRdBit    = 34;  // action_a: read after address load
  localparam int unsigned JdoAddrLsb  = 17;  // action_a: new jaddr
  localparam int unsigned JdoWdataLsb = 3;   // action_b: 32-bit write data

endpackage

// File: rtl/soc_system_nios2_gen2_0_cpu_ocimem_jcmd.sv
// JTAG command front end: decodes the three command strobes, holds a single
// pending command, the JTAG word address and the sticky overrun flag.
// Define OCIMEM_JTAG_AUTOINC_EN to post-increment jaddr after each JTAG access.
module soc_system_nios2_gen2_0_cpu_ocimem_jcmd
  import soc_system_nios2_gen2_0_cpu_ocimem_arbiter_pkg::*;
#(
  parameter int unsigned RAM_AW = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [JdoWidth-1:0]        jdo,
  input  logic                       take_action_ocimem_a,
  input  logic                       take_no_action_ocimem_a,
  input  logic                       take_action_ocimem_b,
  input  logic                       grant_i,
  input  logic                       done_i,
  output logic                       req_o,
  output jop_t                       op_o,
  output logic [RAM_AW-1:0]          addr_o,
  output logic [31:0]                wdata_o,
  output logic                       busy_o,
  output logic                       overrun_o
);

  logic              busy_q, busy_d;
  logic              pend_q, pend_d;
  logic              overrun_q, overrun_d;
  jop_t              op_q, op_d;
  logic [RAM_AW-1:0] jaddr_q, jaddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              any_strobe;
  logic              accept;
  jop_t              new_op;
  logic [RAM_AW-1:0] new_addr;
  logic [31:0]       new_wdata;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[JdoWidth-1:JdoRdBit+1], jdo[JdoWdataLsb-1:0]};

  // Decode the strobe; a fresh command is offered to the arbiter in the same cycle.
  always_comb begin
    any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    accept     = any_strobe & ~busy_q;
    new_op     = JopNone;
    new_addr   = jaddr_q;
    new_wdata  = jdo[JdoWdataLsb +: 32];
    if (take_action_ocimem_a) begin
      new_addr = jdo[JdoAddrLsb +: RAM_AW];
      if (jdo[JdoRdBit]) new_op = JopRead;
    end else if (take_no_action_ocimem_a) begin
      new_op = JopRead;
    end else if (take_action_ocimem_b) begin
      new_op = JopWrite;
    end
    // jaddr_q is frozen while busy, so it still addresses the pending command.
    req_o   = pend_q | (accept & (new_op != JopNone));
    op_o    = pend_q ? op_q : new_op;
    addr_o  = pend_q ? jaddr_q : new_addr;
    wdata_o = pend_q ? wdata_q : new_wdata;
  end

  // Next-state for pending/busy tracking, jaddr and the overrun flag.
  always_comb begin
    busy_d    = busy_q;
    pend_d    = pend_q;
    overrun_d = overrun_q;
    op_d      = op_q;
    jaddr_d   = jaddr_q;
    wdata_d   = wdata_q;
    if (accept) begin
      jaddr_d = new_addr;
      if (new_op != JopNone) begin
        busy_d  = 1'b1;
        pend_d  = 1'b1;
        op_d    = new_op;
        wdata_d = new_wdata;
      end
    end else if (any_strobe) begin
      overrun_d = 1'b1;
    end
    // Clearing wins over a simultaneous drop of the same strobe.
    if (take_action_ocimem_a) overrun_d = 1'b0;
    if (grant_i) pend_d = 1'b0;
    if (done_i) begin
      busy_d = 1'b0;
`ifdef OCIMEM_JTAG_AUTOINC_EN
      jaddr_d = jaddr_q + {{(RAM_AW-1){1'b0}}, 1'b1};
`else
      jaddr_d = jaddr_q;
`endif
    end
  end

  // Command state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= 1'b0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
      op_q      <= JopNone;
      jaddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      op_q      <= op_d;
      jaddr_q   <= jaddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/soc_system_nios2_gen2_0_cpu_ocimem_arbiter.sv
// OCI memory arbiter: shares one single-port RAM (1-cycle read latency)
// between the CPU debug slave and JTAG commands with round-robin on ties.
// Build option OCIMEM_JTAG_AUTOINC_EN is handled in the jcmd sub-module.
module soc_system_nios2_gen2_0_cpu_ocimem_arbiter
  import soc_system_nios2_gen2_0_cpu_ocimem_arbiter_pkg::*;
#(
  parameter int unsigned RAM_AW = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [JdoWidth-1:0] jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_no_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic [RAM_AW-1:0]   av_address,
  input  logic                av_read,
  input  logic                av_write,
  input  logic [31:0]         av_writedata,
  input  logic [3:0]          av_byteenable,
  output logic [31:0]         av_readdata,
  output logic                av_waitrequest,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [31:0]         ram_wdata,
  output logic [3:0]          ram_be,
  output logic                ram_we,
  output logic                ram_re,
  input  logic [31:0]         ram_rdata,
  output logic [31:0]         MonDReg,
  output logic                monitor_ready,
  output logic                jtag_overrun
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_q, last_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic [3:0]        ram_be_q, ram_be_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic [31:0]       mon_q, mon_d;
  logic [31:0]       av_rdata_q, av_rdata_d;

  logic              av_req, av_done;
  logic              grant_j, grant_av;
  logic              j_req, j_done, j_busy;
  jop_t              j_op;
  logic [RAM_AW-1:0] j_addr;
  logic [31:0]       j_wdata;

  soc_system_nios2_gen2_0_cpu_ocimem_jcmd #(
    .RAM_AW(RAM_AW)
  ) u_jcmd (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .grant_i                 (grant_j),
    .done_i                  (j_done),
    .req_o                   (j_req),
    .op_o                    (j_op),
    .addr_o                  (j_addr),
    .wdata_o                 (j_wdata),
    .busy_o                  (j_busy),
    .overrun_o               (jtag_overrun)
  );

  // Arbitration in IDLE; on a tie the side not granted last wins.
  always_comb begin
    av_req   = av_read | av_write;
    grant_j  = 1'b0;
    grant_av = 1'b0;
    if (state_q == StIdle) begin
      if (j_req && av_req) begin
        if (last_q == OWN_AV) grant_j = 1'b1;
        else                  grant_av = 1'b1;
      end else if (j_req) begin
        grant_j = 1'b1;
      end else if (av_req) begin
        grant_av = 1'b1;
      end
    end
    av_done = (owner_q == OWN_AV) & ((state_q == StWr) | (state_q == StRdCap));
    j_done  = (owner_q == OWN_JTAG) & ((state_q == StWr) | (state_q == StRdCap));
  end

  // FSM next-state and registered RAM strobes/address/data.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_be_d    = ram_be_q;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    mon_d       = mon_q;
    av_rdata_d  = av_rdata_q;
    case (state_q)
      StIdle: begin
        if (grant_j) begin
          owner_d    = OWN_JTAG;
          last_d     = OWN_JTAG;
          ram_addr_d = j_addr;
          if (j_op == JopWrite) begin
            state_d     = StWr;
            ram_we_d    = 1'b1;
            ram_wdata_d = j_wdata;
            ram_be_d    = 4'hF;
          end else begin
            state_d  = StRd;
            ram_re_d = 1'b1;
          end
        end else if (grant_av) begin
          owner_d    = OWN_AV;
          last_d     = OWN_AV;
          ram_addr_d = av_address;
          // A simultaneous read and write is served as a write.
          if (av_write) begin
            state_d     = StWr;
            ram_we_d    = 1'b1;
            ram_wdata_d = av_writedata;
            ram_be_d    = av_byteenable;
          end else begin
            state_d  = StRd;
            ram_re_d = 1'b1;
          end
        end
      end
      StWr:   state_d = StIdle;
      StRd:   state_d = StRdCap;
      StRdCap: begin
        state_d = StIdle;
        if (owner_q == OWN_JTAG) mon_d = ram_rdata;
        else                     av_rdata_d = ram_rdata;
      end
      default: state_d = StIdle;
    endcase
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OWN_AV;
      last_q      <= OWN_AV;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_be_q    <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      mon_q       <= '0;
      av_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_be_q    <= ram_be_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      mon_q       <= mon_d;
      av_rdata_q  <= av_rdata_d;
    end
  end

  // Read data is forwarded during RDCAP so the slave completes at N+2.
  assign av_readdata    = ((state_q == StRdCap) && (owner_q == OWN_AV)) ? ram_rdata : av_rdata_q;
  assign av_waitrequest = av_req & ~av_done;
  assign ram_addr       = ram_addr_q;
  assign ram_wdata      = ram_wdata_q;
  assign ram_be         = ram_be_q;
  assign ram_we         = ram_we_q;
  assign ram_re         = ram_re_q;
  assign MonDReg        = mon_q;
  assign monitor_ready  = ~j_busy;

endmodule

// File: tb/tb_soc_system_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Bench for the OCI memory arbiter: directed scenarios followed by random
// Avalon/JTAG/reset traffic, all checked every cycle against a
// transaction-level reference model.
module tb_soc_system_nios2_gen2_0_cpu_ocimem_arbiter;

`ifdef OCIMEM_JTAG_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  logic        clk = 1'b1;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready, jtag_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  soc_system_nios2_gen2_0_cpu_ocimem_arbiter #(
    .RAM_AW(8)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_be                  (ram_be),
    .ram_we                  (ram_we),
    .ram_re                  (ram_re),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // RAM attached to the DUT: 1-cycle read latency, garbage when not reading.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (ram_we === 1'b1) ram[ram_addr] <= merge(ram[ram_addr], ram_wdata, ram_be);
    ram_rdata <= (ram_re === 1'b1) ? ram[ram_addr] : $urandom;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory image, current RAM access and JTAG command state.
  logic [31:0] mm [256];
  int          m_kind = 0;  // 0 none, 1 write, 2 read
  int          m_step = 0;  // read: 0 = RAM strobe cycle, 1 = data cycle
  bit          m_owner, m_last_jtag, m_jpend, m_jbusy, m_ovr, m_valid, m_avdone_seen;
  int          m_jop;       // 1 read, 2 write
  logic [7:0]  m_addr, m_jaddr;
  logic [31:0] m_wdata, m_jwdata, m_mon;
  logic [3:0]  m_be;

  task automatic model_check();
    bit e_avdone;
    e_avdone = (m_kind != 0) && !m_owner && (m_kind == 1 || m_step == 1);
    m_avdone_seen = e_avdone;
    if (!m_valid) return;
    check_eq("ram_we", {31'b0, ram_we}, {31'b0, m_kind == 1});
    check_eq("ram_re", {31'b0, ram_re}, {31'b0, m_kind == 2 && m_step == 0});
    if (m_kind == 1 || (m_kind == 2 && m_step == 0)) check_eq("ram_addr", {24'b0, ram_addr},
                                                             {24'b0, m_addr});
    if (m_kind == 1) begin
      check_eq("ram_wdata", ram_wdata, m_wdata);
      check_eq("ram_be", {28'b0, ram_be}, {28'b0, m_be});
    end
    check_eq("av_waitrequest", {31'b0, av_waitrequest},
             {31'b0, (av_read | av_write) && !e_avdone});
    if (e_avdone && m_kind == 2) check_eq("av_readdata", av_readdata, mm[m_addr]);
    check_eq("MonDReg", MonDReg, m_mon);
    check_eq("monitor_ready", {31'b0, monitor_ready}, {31'b0, !m_jbusy});
    check_eq("jtag_overrun", {31'b0, jtag_overrun}, {31'b0, m_ovr});
  endtask

  task automatic model_step();
    bit fin, idle_now, busy0, g_j, g_av, avreq;
    fin = (m_kind == 1) || (m_kind == 2 && m_step == 1);
    // The RAM itself is never reset, so a write in flight still lands.
    if (m_kind == 1) mm[m_addr] = merge(mm[m_addr], m_wdata, m_be);
    if (reset) begin
      m_kind = 0; m_step = 0; m_jaddr = 0; m_jpend = 0; m_jbusy = 0;
      m_ovr = 0; m_last_jtag = 0; m_mon = 0; m_valid = 1;
      return;
    end
    idle_now = (m_kind == 0);
    busy0    = m_jbusy;
    if (fin && m_owner) begin
      if (m_kind == 2) m_mon = mm[m_addr];
      m_jbusy = 0;
      if (AutoInc) m_jaddr = m_jaddr + 8'd1;
    end
    if (take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b) begin
      if (busy0) m_ovr = 1;
      else if (take_action_ocimem_a) begin
        m_jaddr = jdo[24:17];
        if (jdo[34]) begin m_jop = 1; m_jpend = 1; m_jbusy = 1; end
      end else begin
        m_jop   = take_no_action_ocimem_a ? 1 : 2;
        m_jwdata = jdo[34:3];
        m_jpend = 1; m_jbusy = 1;
      end
    end
    if (take_action_ocimem_a) m_ovr = 0;
    avreq = av_read | av_write;
    g_j = 0; g_av = 0;
    if (idle_now) begin
      if (m_jpend && avreq) begin
        if (m_last_jtag) g_av = 1; else g_j = 1;
      end else if (m_jpend) g_j = 1;
      else if (avreq) g_av = 1;
    end
    if (m_kind == 2 && m_step == 0) m_step = 1; else m_kind = 0;
    if (g_j) begin
      m_owner = 1; m_last_jtag = 1; m_jpend = 0; m_addr = m_jaddr; m_step = 0;
      if (m_jop == 2) begin m_kind = 1; m_wdata = m_jwdata; m_be = 4'hF; end
      else m_kind = 2;
    end
    if (g_av) begin
      m_owner = 0; m_last_jtag = 0; m_addr = av_address; m_step = 0;
      if (av_write) begin m_kind = 1; m_wdata = av_writedata; m_be = av_byteenable; end
      else m_kind = 2;
    end
  endtask

  // One clock: check at the falling edge, advance model at the rising edge.
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input bit rd);
    logic [37:0] j;
    j = '0; j[24:17] = a; j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0; j[34:3] = d;
    return j;
  endfunction

  task automatic clr_strobes();
    take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
  endtask

  initial begin
    logic [31:0] v;
    int r;
    bit av_active;
    for (int i = 0; i < 256; i++) begin
      v = $urandom; ram[i] = v; mm[i] = v;
    end
    ram[8'h10] = 32'h12345678; mm[8'h10] = 32'h12345678;
    reset = 1; jdo = '0; clr_strobes();
    av_address = '0; av_read = 0; av_write = 0; av_writedata = '0; av_byteenable = '0;
    tick(); tick();
    reset = 0;
    check_eq("rst_ram_wdata", ram_wdata, 32'h0);
    check_eq("rst_ram_be", {28'b0, ram_be}, 32'h0);
    check_eq("rst_av_readdata", av_readdata, 32'h0);
    tick();

    // JTAG write of DEADBEEF at jaddr 5.
    jdo = jdo_a(8'd5, 1'b0); take_action_ocimem_a = 1; tick(); clr_strobes();
    jdo = jdo_b(32'hDEADBEEF); take_action_ocimem_b = 1; tick(); clr_strobes();
    check_eq("j_wr_we", {31'b0, ram_we}, 32'd1);
    check_eq("j_wr_addr", {24'b0, ram_addr}, 32'd5);
    check_eq("j_wr_data", ram_wdata, 32'hDEADBEEF);
    tick();
    check_eq("j_wr_ready", {31'b0, monitor_ready}, 32'd1);

    // Avalon read of 0x10.
    av_address = 8'h10; av_read = 1; tick();
    check_eq("av_rd_re", {31'b0, ram_re}, 32'd1);
    check_eq("av_rd_wait1", {31'b0, av_waitrequest}, 32'd1);
    tick();
    check_eq("av_rd_data", av_readdata, 32'h12345678);
    check_eq("av_rd_wait2", {31'b0, av_waitrequest}, 32'd0);
    av_read = 0; tick();

    // Tie with held Avalon write: JTAG first, then alternation.
    av_address = 8'h40; av_writedata = 32'hA5A5A5A5; av_byteenable = 4'hF; av_write = 1;
    jdo = jdo_b(32'h11111111); take_action_ocimem_b = 1; tick(); clr_strobes();
    check_eq("tie1_data", ram_wdata, 32'h11111111);
    tick();
    jdo = jdo_b(32'h22222222); take_action_ocimem_b = 1; tick(); clr_strobes();
    check_eq("tie2_data", ram_wdata, 32'hA5A5A5A5);
    av_write = 0; tick(); tick();
    check_eq("tie3_data", ram_wdata, 32'h22222222);
    tick(); tick();

    // Back-to-back strobes: second dropped, overrun cleared by action_a.
    take_no_action_ocimem_a = 1; tick(); clr_strobes();
    jdo = jdo_b(32'h33333333); take_action_ocimem_b = 1; tick(); clr_strobes();
    tick(); tick(); tick();
    check_eq("ovr_set", {31'b0, jtag_overrun}, 32'd1);
    jdo = jdo_a(8'd7, 1'b0); take_action_ocimem_a = 1; tick(); clr_strobes();
    check_eq("ovr_clr", {31'b0, jtag_overrun}, 32'd0);

    // jaddr wrap at 0xFF.
    jdo = jdo_a(8'hFF, 1'b1); take_action_ocimem_a = 1; tick(); clr_strobes();
    check_eq("wrap_rd_addr", {24'b0, ram_addr}, 32'hFF);
    repeat (4) tick();
    take_no_action_ocimem_a = 1; tick(); clr_strobes();
    check_eq("wrap_next_addr", {24'b0, ram_addr}, AutoInc ? 32'h00 : 32'hFF);
    repeat (3) tick();

    // Reset during RD abandons the access.
    av_address = 8'h33; av_read = 1; tick();
    reset = 1; av_read = 0; tick(); reset = 0;
    check_eq("rst_rd_re", {31'b0, ram_re}, 32'd0);
    check_eq("rst_rd_addr", {24'b0, ram_addr}, 32'd0);
    check_eq("rst_rd_avdata", av_readdata, 32'd0);
    check_eq("rst_rd_wait", {31'b0, av_waitrequest}, 32'd0);
    check_eq("rst_rd_mon", MonDReg, 32'd0);
    check_eq("rst_rd_ready", {31'b0, monitor_ready}, 32'd1);
    tick();

    // Random mixed traffic.
    av_active = 0;
    for (int c = 0; c < 3000; c++) begin
      if (av_active && m_avdone_seen) begin
        av_active = 0; av_read = 0; av_write = 0;
      end
      if (!av_active && $urandom_range(0, 2) == 0) begin
        av_active = 1;
        av_address = 8'($urandom); av_writedata = $urandom; av_byteenable = 4'($urandom);
        r = $urandom_range(0, 3);
        av_read  = (r != 0);
        av_write = (r == 0) || (r == 2);
      end
      clr_strobes();
      if ($urandom_range(0, 3) == 0) begin
        jdo = {6'($urandom), $urandom};
        r = $urandom_range(0, 2);
        if (r == 0) take_action_ocimem_a = 1;
        else if (r == 1) take_no_action_ocimem_a = 1;
        else take_action_ocimem_b = 1;
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0; clr_strobes(); av_read = 0; av_write = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_system_nios2_gen2_0_cpu_ocimem_arbiter.md
SOC_SYSTEM_NIOS2_GEN2_0_CPU_OCIMEM_ARBITER -- requirements
Module: soc_system_nios2_gen2_0_cpu_ocimem_arbiter

Interface
REQ-001 SHALL have parameter RAM_AW, default 8, OCI memory word-address width.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port jdo, input, 38, JTAG command data in the sysclk domain.
REQ-005 SHALL have ports take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b, input, 1 each, single-cycle JTAG command strobes.
REQ-006 SHALL have ports av_address (RAM_AW), av_read (1), av_write (1), av_writedata (32), av_byteenable (4), inputs, CPU debug-slave request.
REQ-007 SHALL have ports av_readdata (32) and av_waitrequest (1), outputs, CPU debug-slave response.
REQ-008 SHALL have ports ram_addr (RAM_AW), ram_wdata (32), ram_be (4), ram_we (1), ram_re (1), outputs, and ram_rdata (32), input, single-port RAM with 1-cycle read latency.
REQ-009 SHALL have ports MonDReg (32), monitor_ready (1), jtag_overrun (1), outputs, JTAG readback, JTAG-idle flag and sticky drop flag.

Function
REQ-010 SHALL decode strobes: action_a = set jaddr from jdo[17+RAM_AW-1:17], then read if jdo[34]=1; no_action_a = read at jaddr; action_b = write jdo[34:3] at jaddr, ram_be=4'hF.
REQ-011 SHALL hold one pending JTAG command; a strobe arriving while a command is pending or executing SHALL be dropped and set jtag_overrun.
REQ-012 SHALL sequence with FSM IDLE, WR, RD, RDCAP; all ram_* outputs registered.
REQ-013 IDLE: on grant go to WR (ram_we=1 for 1 cycle) or RD (ram_re=1 for 1 cycle); RD -> RDCAP; RDCAP and WR -> IDLE.
REQ-014 RDCAP SHALL capture ram_rdata into MonDReg (JTAG owner) or av_readdata (Avalon owner).
REQ-015 Arbitration in IDLE: only one requester -> grant it; both -> grant the requester not granted last (last-grant register resets to Avalon, so JTAG wins first tie).
REQ-016 Avalon write granted at cycle N: ram_we high at N+1, av_waitrequest low at N+1 only.
REQ-017 Avalon read granted at cycle N: ram_re at N+1, av_readdata valid and av_waitrequest low at N+2 only.
REQ-018 av_waitrequest SHALL be high whenever av_read|av_write is high and that cycle is not the completion cycle; low when no request.
REQ-019 av_read and av_write both high SHALL be treated as a write.
REQ-020 monitor_ready SHALL be low from strobe acceptance until the cycle after the JTAG command's WR or RDCAP, high otherwise.
REQ-021 jaddr SHALL wrap from 2^RAM_AW-1 to 0 on increment.
REQ-022 action_a SHALL clear jtag_overrun, including when the same strobe is dropped (then clear wins).
REQ-023 MonDReg SHALL change only in JTAG RDCAP.

Reset
REQ-024 On reset: FSM IDLE, pending cleared, jaddr=0, last-grant=Avalon, all ram_* outputs 0, MonDReg=0, av_readdata=0, av_waitrequest=0, jtag_overrun=0, monitor_ready=1.
REQ-025 Reset mid-operation SHALL abandon the access without a further ram_we/ram_re pulse; the in-flight Avalon request restarts from IDLE after reset.

Configuration
REQ-026 With OCIMEM_JTAG_AUTOINC_EN defined, jaddr SHALL increment by 1 after every JTAG read (RDCAP) and write (WR).
REQ-027 Without OCIMEM_JTAG_AUTOINC_EN, jaddr SHALL change only on action_a.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, owner enum (OWN_AV, OWN_JTAG), JTAG opcode enum, and jdo field bit-position constants.
REQ-029 One sub-module, soc_system_nios2_gen2_0_cpu_ocimem_jcmd, SHALL decode strobes and hold the pending command, jaddr and jtag_overrun.

Verification
REQ-030 After reset, action_b with jdo[34:3]=32'hDEADBEEF at jaddr 5 -> ram_we=1 one cycle later, ram_addr=5, ram_wdata=32'hDEADBEEF, monitor_ready high again.
REQ-031 Avalon read addr 8'h10, RAM returns 32'h12345678 -> ram_re at N+1, av_readdata=32'h12345678 with av_waitrequest low at N+2.
REQ-032 Avalon write held and JTAG strobe in the same cycle -> JTAG granted first, Avalon next; alternation on repeated ties.
REQ-033 Two strobes 1 cycle apart -> second dropped, jtag_overrun=1; next action_a clears it.
REQ-034 OCIMEM_JTAG_AUTOINC_EN defined, jaddr=8'hFF, no_action_a -> read at FF, jaddr wraps to 0; undefined -> jaddr stays FF.
REQ-035 reset asserted in RD -> no RDCAP capture, all outputs at reset values next cycle.
